// File: rtl/iic_pkg.sv
// Shared definitions for the I2C register-slave block.
//   SLAVE_ADDR_DEF, IIC_AW_DEF, IIC_DW_DEF : parameter defaults
//   iic_state_e                            : protocol FSM state encoding
package iic_pkg;

  localparam logic [6:0]  SLAVE_ADDR_DEF = 7'h50;
  localparam int unsigned IIC_AW_DEF     = 2;
  localparam int unsigned IIC_DW_DEF     = 8;

  typedef enum logic [3:0] {
    StIdle,
    StDevAddr,
    StDevAck,
    StRegAddr,
    StRegAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck
  } iic_state_e;

endpackage

// File: rtl/iic_slave_if_if.sv
// Bundle of the I2C bus lines and the register port of iic_slave_if.
//   i_scl, i_sda      : raw bus lines (asynchronous)
//   o_sda_oe          : 1 = slave pulls SDA low
//   o_reg_ce/we/oe    : register-port controls
//   o_reg_addr        : register address pointer
//   o_reg_data        : write data
//   i_reg_data        : read data
//   o_busy            : protocol engine not idle
// Modports: slave (the I2C block), master (bus driver / register file side).
interface iic_slave_if_if
  import iic_pkg::*;
#(
  parameter int unsigned IIC_AW = IIC_AW_DEF,
  parameter int unsigned IIC_DW = IIC_DW_DEF
) ();

  logic              i_scl;
  logic              i_sda;
  logic              o_sda_oe;
  logic              o_reg_ce;
  logic              o_reg_we;
  logic              o_reg_oe;
  logic [IIC_AW-1:0] o_reg_addr;
  logic [IIC_DW-1:0] o_reg_data;
  logic [IIC_DW-1:0] i_reg_data;
  logic              o_busy;

  modport slave (
    input  i_scl, i_sda, i_reg_data,
    output o_sda_oe, o_reg_ce, o_reg_we, o_reg_oe, o_reg_addr, o_reg_data, o_busy
  );

  modport master (
    output i_scl, i_sda, i_reg_data,
    input  o_sda_oe, o_reg_ce, o_reg_we, o_reg_oe, o_reg_addr, o_reg_data, o_busy
  );

endinterface

// File: rtl/iic_line_filter.sv
// Two-flop synchroniser for one raw I2C line, with an optional 3-sample
// majority filter enabled by macro IIC_GLITCH_FILT_EN (adds 2 clk latency).
//   i_iic_clk   : system clock
//   i_iic_rst_n : asynchronous active-low reset (line resets to idle-high)
//   i_line      : raw asynchronous line
//   o_line      : synchronised (and optionally filtered) line
module iic_line_filter
  import iic_pkg::*;
(
  input  logic i_iic_clk,
  input  logic i_iic_rst_n,
  input  logic i_line,
  output logic o_line
);

  logic [1:0] sync_q;

  always_ff @(posedge i_iic_clk or negedge i_iic_rst_n) begin
    if (!i_iic_rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], i_line};
    end
  end

`ifdef IIC_GLITCH_FILT_EN
  logic [1:0] hist_q;
  logic       maj_q;

  // Majority of the current and two previous samples; a single-clk pulse never wins.
  always_ff @(posedge i_iic_clk or negedge i_iic_rst_n) begin
    if (!i_iic_rst_n) begin
      hist_q <= 2'b11;
      maj_q  <= 1'b1;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      maj_q  <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign o_line = maj_q;
`else
  assign o_line = sync_q[1];
`endif

endmodule

// File: rtl/iic_slave_if.sv
// I2C slave exposing a small register port. Writes: S, dev+W, reg addr, data...
// Reads: S, dev+R, data... with auto-increment of the address pointer (mod 2^IIC_AW).
// Optional glitch filtering of SCL/SDA with macro IIC_GLITCH_FILT_EN.
//   i_iic_clk   : system clock (rising edge)
//   i_iic_rst_n : asynchronous active-low reset
//   bus         : iic_slave_if_if.slave (bus lines + register port + busy)
module iic_slave_if
  import iic_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = SLAVE_ADDR_DEF,
  parameter int unsigned IIC_AW     = IIC_AW_DEF,
  parameter int unsigned IIC_DW     = IIC_DW_DEF
) (
  input logic           i_iic_clk,
  input logic           i_iic_rst_n,
  iic_slave_if_if.slave bus
);

  logic scl_f, sda_f, scl_q, sda_q;
  logic scl_rise, scl_fall, start, stop;

  iic_line_filter u_scl_filt (
    .i_iic_clk  (i_iic_clk),
    .i_iic_rst_n(i_iic_rst_n),
    .i_line     (bus.i_scl),
    .o_line     (scl_f)
  );

  iic_line_filter u_sda_filt (
    .i_iic_clk  (i_iic_clk),
    .i_iic_rst_n(i_iic_rst_n),
    .i_line     (bus.i_sda),
    .o_line     (sda_f)
  );

  assign scl_rise = scl_f & ~scl_q;
  assign scl_fall = ~scl_f & scl_q;
  // SDA edges only count as conditions while SCL stays high across both samples.
  assign start    = scl_f & scl_q & sda_q & ~sda_f;
  assign stop     = scl_f & scl_q & ~sda_q & sda_f;

  iic_state_e        state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [6:0]        tx_q, tx_d;       // read bits still to be shifted out after the MSB
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              we_q, we_d;
  logic              inc_q, inc_d;     // bump the address pointer on the next clk
  logic [IIC_AW-1:0] addr_q, addr_d;
  logic [IIC_DW-1:0] data_q, data_d;
  logic [7:0]        rd_byte;
  logic              load_tx;
  logic              reg_oe;

  assign rd_byte = 8'(bus.i_reg_data);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    we_d      = 1'b0;
    inc_d     = 1'b0;
    data_d    = data_q;
    addr_d    = inc_q ? addr_q + IIC_AW'(1) : addr_q;
    load_tx   = 1'b0;

    if (start) begin
      state_d   = StDevAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (state_q != StIdle) begin
      if (scl_rise) begin
        shift_d = {shift_q[6:0], sda_f};
        if (bit_cnt_q < 4'd9) bit_cnt_d = bit_cnt_q + 4'd1;
      end
      if (scl_fall) begin
        case (state_q)
          StDevAddr: begin
            if (bit_cnt_q == 4'd8) begin
              if (shift_q[7:1] == SLAVE_ADDR) begin
                state_d  = StDevAck;
                sda_oe_d = 1'b1;
                rw_d     = shift_q[0];
              end else begin
                state_d  = StIdle;
                sda_oe_d = 1'b0;
              end
            end
          end
          StRegAddr: begin
            if (bit_cnt_q == 4'd8) begin
              addr_d   = shift_q[IIC_AW-1:0];
              state_d  = StRegAck;
              sda_oe_d = 1'b1;
            end
          end
          StWrData: begin
            if (bit_cnt_q == 4'd8) begin
              data_d   = IIC_DW'(shift_q);
              we_d     = 1'b1;
              inc_d    = 1'b1;
              state_d  = StWrAck;
              sda_oe_d = 1'b1;
            end
          end
          StDevAck: begin
            if (rw_q) begin
              load_tx = 1'b1;
            end else begin
              state_d   = StRegAddr;
              bit_cnt_d = '0;
              sda_oe_d  = 1'b0;
            end
          end
          StRegAck, StWrAck: begin
            state_d   = StWrData;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end
          StRdData: begin
            if (bit_cnt_q == 4'd8) begin
              state_d  = StRdAck;
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
          StRdAck: begin
            // shift_q[0] holds the master's ACK bit sampled on the last rise
            if (!shift_q[0]) begin
              load_tx = 1'b1;
            end else begin
              state_d  = StIdle;
              sda_oe_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end

    if (load_tx) begin
      state_d   = StRdData;
      bit_cnt_d = '0;
      tx_d      = rd_byte[6:0];
      sda_oe_d  = ~rd_byte[7];
      inc_d     = 1'b1;
    end
  end

  always_ff @(posedge i_iic_clk or negedge i_iic_rst_n) begin
    if (!i_iic_rst_n) begin
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      we_q      <= 1'b0;
      inc_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      scl_q     <= scl_f;
      sda_q     <= sda_f;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      we_q      <= we_d;
      inc_q     <= inc_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign reg_oe         = (state_q == StRdData) || (state_q == StRdAck);
  assign bus.o_sda_oe   = sda_oe_q;
  assign bus.o_reg_we   = we_q;
  assign bus.o_reg_oe   = reg_oe;
  assign bus.o_reg_ce   = we_q | reg_oe;
  assign bus.o_reg_addr = addr_q;
  assign bus.o_reg_data = data_q;
  assign bus.o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_iic_slave_if.sv
// Self-checking bench for iic_slave_if: bit-banged I2C master, a 4-entry
// register file fed by the write strobes, and a transaction-level model
// (array + pointer) giving every expected value.
module tb_iic_slave_if;
  import iic_pkg::*;

  localparam int unsigned Q = 100;  // quarter SCL period

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [4] = '{default: 8'h00};
  int         strobe_q[$];
  int         ce_cnt = 0;

  logic [7:0] model_mem [4] = '{default: 8'h00};
  int         model_ptr = 0;
  int         exp_q[$];
  int         checked = 0;

  always #5 clk = ~clk;

  iic_slave_if_if #(.IIC_AW(IIC_AW_DEF), .IIC_DW(8)) bus ();

  assign bus.i_scl      = m_scl;
  assign bus.i_sda      = m_sda & ~bus.o_sda_oe;
  assign bus.i_reg_data = mem[bus.o_reg_addr];

  iic_slave_if #(.SLAVE_ADDR(7'h50), .IIC_AW(IIC_AW_DEF), .IIC_DW(8)) dut (
    .i_iic_clk  (clk),
    .i_iic_rst_n(rst_n),
    .bus        (bus)
  );

  // Register file behind the port; records every strobe seen.
  always @(negedge clk) begin
    if (bus.o_reg_ce && bus.o_reg_we) begin
      mem[bus.o_reg_addr] <= bus.o_reg_data;
      strobe_q.push_back(int'(bus.o_reg_addr) * 256 + int'(bus.o_reg_data));
    end
    if (bus.o_reg_ce && !bus.o_reg_oe) ce_cnt <= ce_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input logic [7:0] d);
    exp_q.push_back(model_ptr * 256 + int'(d));
    model_mem[model_ptr] = d;
    model_ptr = (model_ptr + 1) % 4;
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_strobe_cnt"}, 32'(strobe_q.size()), 32'(exp_q.size()));
    for (int i = checked; i < exp_q.size() && i < strobe_q.size(); i++)
      check({tag, "_strobe"}, 32'(strobe_q[i]), 32'(exp_q[i]));
    checked = exp_q.size();
  endtask

  task automatic bus_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q;
  endtask

  // Optional 1-clk low pulse on SCL in the middle of the high phase.
  task automatic put_bit(input logic b, input bit glitch);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q;
    if (glitch) begin
      m_scl = 1'b0; #10;
      m_scl = 1'b1;
    end
    #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], glitch && (i == 4));
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    ack = bus.i_sda; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] d, output logic oe_mid);
    d = 8'h00;
    oe_mid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_sda = 1'b1; #Q;
      m_scl = 1'b1; #Q;
      d = {d[6:0], bus.i_sda};
      if (i == 7) oe_mid = bus.o_reg_oe;
      #Q;
      m_scl = 1'b0; #Q;
    end
    put_bit(nack, 1'b0);
  endtask

  task automatic write_txn(input logic [7:0] ra, input int n, input logic [23:0] dat,
                           input bit glitch, input string tag);
    logic ack;
    logic [7:0] d;
    bus_start();
    put_byte(8'hA0, 1'b0, ack);
    check({tag, "_dev_ack"}, 32'(ack), 32'd0);
    put_byte(ra, 1'b0, ack);
    check({tag, "_reg_ack"}, 32'(ack), 32'd0);
    model_ptr = int'(ra[1:0]);
    for (int i = 0; i < n; i++) begin
      d = dat[23-8*i -: 8];
      put_byte(d, glitch, ack);
      check({tag, "_data_ack"}, 32'(ack), 32'd0);
      exp_write(d);
    end
    bus_stop();
    check_strobes(tag);
    check({tag, "_addr"}, 32'(bus.o_reg_addr), 32'(model_ptr));
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic read_txn(input bit set_addr, input logic [7:0] ra, input int n,
                          input string tag);
    logic ack;
    logic oe_mid;
    logic [7:0] d;
    bus_start();
    if (set_addr) begin
      put_byte(8'hA0, 1'b0, ack);
      check({tag, "_dev_ack"}, 32'(ack), 32'd0);
      put_byte(ra, 1'b0, ack);
      check({tag, "_reg_ack"}, 32'(ack), 32'd0);
      model_ptr = int'(ra[1:0]);
      check({tag, "_oe_before"}, 32'(bus.o_reg_oe), 32'd0);
      bus_start();
    end
    put_byte(8'hA1, 1'b0, ack);
    check({tag, "_rd_dev_ack"}, 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      get_byte(i == n - 1, d, oe_mid);
      check({tag, "_rd_data"}, 32'(d), 32'(model_mem[model_ptr]));
      check({tag, "_oe_during"}, 32'(oe_mid), 32'd1);
      model_ptr = (model_ptr + 1) % 4;
    end
    bus_stop();
    check({tag, "_oe_after"}, 32'(bus.o_reg_oe), 32'd0);
    check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
    check({tag, "_addr"}, 32'(bus.o_reg_addr), 32'(model_ptr));
    check_strobes(tag);
  endtask

  initial begin
    logic ack;
    int   ce_before;
    #42;
    check("rst_sda_oe", 32'(bus.o_sda_oe), 32'd0);
    check("rst_ce", 32'(bus.o_reg_ce), 32'd0);
    check("rst_we", 32'(bus.o_reg_we), 32'd0);
    check("rst_oe", 32'(bus.o_reg_oe), 32'd0);
    check("rst_addr", 32'(bus.o_reg_addr), 32'd0);
    check("rst_data", 32'(bus.o_reg_data), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    rst_n = 1'b1;
    #40;

    // Single write, then wrap-around burst.
    write_txn(8'h00, 1, 24'hC30000, 1'b0, "wr_c3");
    write_txn(8'h03, 2, 24'hAA5500, 1'b0, "wrap");

    // Write 0x32 at 1, then set pointer and read it back with NACK.
    write_txn(8'h01, 1, 24'h320000, 1'b0, "prep32");
    read_txn(1'b1, 8'h01, 1, "rd32");

    // Wrong device address: NACK, idle, no register activity.
    ce_before = ce_cnt;
    bus_start();
    put_byte(8'hA2, 1'b0, ack);
    check("badaddr_nack", 32'(ack), 32'd1);
    check("badaddr_busy", 32'(bus.o_busy), 32'd0);
    put_byte(8'h11, 1'b0, ack);
    check("badaddr_nack2", 32'(ack), 32'd1);
    bus_stop();
    check("badaddr_ce", 32'(ce_cnt), 32'(ce_before));
    check_strobes("badaddr");

    // Randomised mix of write bursts and reads.
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 1)
        write_txn(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)), 24'($urandom()),
                  1'b0, "rnd_wr");
      else
        read_txn($urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)),
                 int'($urandom_range(1, 3)), "rnd_rd");
    end

    // STOP after 4 bits of a data byte: nothing written.
    bus_start();
    put_byte(8'hA0, 1'b0, ack);
    put_byte(8'h00, 1'b0, ack);
    model_ptr = 0;
    for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0);
    bus_stop();
    check_strobes("partial");
    check("partial_busy", 32'(bus.o_busy), 32'd0);
    check("partial_sda", 32'(bus.o_sda_oe), 32'd0);
    check("partial_addr", 32'(bus.o_reg_addr), 32'd0);

    // Reset in the middle of a read that is pulling SDA low.
    write_txn(8'h01, 1, 24'h000000, 1'b0, "prep00");
    bus_start();
    put_byte(8'hA0, 1'b0, ack);
    put_byte(8'h01, 1'b0, ack);
    bus_start();
    put_byte(8'hA1, 1'b0, ack);
    check("rdrst_sda_before", 32'(bus.o_sda_oe), 32'd1);
    check("rdrst_oe_before", 32'(bus.o_reg_oe), 32'd1);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    rst_n = 1'b0;
    #1;
    check("rdrst_sda", 32'(bus.o_sda_oe), 32'd0);
    check("rdrst_busy", 32'(bus.o_busy), 32'd0);
    check("rdrst_addr", 32'(bus.o_reg_addr), 32'd0);
    model_ptr = 0;
    #29;
    rst_n = 1'b1;
    #Q;
    m_scl = 1'b0; #Q;
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    check("postrst_busy", 32'(bus.o_busy), 32'd0);
    check("postrst_sda", 32'(bus.o_sda_oe), 32'd0);
    bus_stop();
    write_txn(8'h02, 1, 24'h5A0000, 1'b0, "postrst");

`ifdef IIC_GLITCH_FILT_EN
    write_txn(8'h00, 2, 24'h96E100, 1'b1, "glitch");
    read_txn(1'b1, 8'h00, 2, "glitch_rd");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iic_slave_if.md
IIC_SLAVE_IF -- requirements
Module: iic_slave_if

Interface
REQ-001 SHALL provide parameter SLAVE_ADDR, default 7'h50, the 7-bit device address answered on the bus.
REQ-002 SHALL provide parameter IIC_AW, default 2, the register address width.
REQ-003 SHALL provide parameter IIC_DW, default 8, the register data width.
REQ-004 SHALL provide port i_iic_clk  in  1  system clock; all logic is clocked on its rising edge.
REQ-005 SHALL provide port i_iic_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port i_scl  in  1  raw bus SCL, asynchronous to i_iic_clk.
REQ-007 SHALL provide port i_sda  in  1  raw bus SDA, asynchronous to i_iic_clk.
REQ-008 SHALL provide port o_sda_oe  out  1  1 = pull SDA low; 0 = release SDA.
REQ-009 SHALL provide port o_reg_ce  out  1  register-port chip enable.
REQ-010 SHALL provide port o_reg_we  out  1  register-port write strobe.
REQ-011 SHALL provide port o_reg_oe  out  1  register-port output enable.
REQ-012 SHALL provide port o_reg_addr  out  IIC_AW  register address pointer.
REQ-013 SHALL provide port o_reg_data  out  IIC_DW  write data.
REQ-014 SHALL provide port i_reg_data  in  IIC_DW  read data, valid 1 clk after o_reg_addr changes.
REQ-015 SHALL provide port o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL synchronise i_scl and i_sda through 2 flops each before any use.
REQ-017 SHALL detect START as filtered SDA falling while SCL is high, and STOP as filtered SDA rising while SCL is high.
REQ-018 SHALL sample SDA on the filtered SCL rising edge and change o_sda_oe only on the filtered SCL falling edge.
REQ-019 SHALL implement the FSM states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
REQ-020 SHALL move from any state to DEV_ADDR on START, covering repeated START.
REQ-021 SHALL move from any state to IDLE on STOP, releasing SDA on the same clk.
REQ-022 SHALL leave DEV_ADDR after 8 bits: address match with R/W=0 -> DEV_ACK (ACK) -> REG_ADDR; match with R/W=1 -> DEV_ACK (ACK) -> RD_DATA; mismatch -> IDLE with SDA released (NACK).
REQ-023 SHALL, in REG_ADDR, after 8 bits load o_reg_addr from the low IIC_AW bits, ACK, then go to WR_DATA.
REQ-024 SHALL, in WR_DATA, after the 8th bit drive o_reg_data and assert o_reg_ce&o_reg_we for exactly one clk.
REQ-025 SHALL, after each write strobe, ACK and then increment o_reg_addr modulo 2^IIC_AW (3 -> 0).
REQ-026 SHALL hold o_reg_oe high in RD_DATA and RD_ACK, and low otherwise.
REQ-027 SHALL load the TX shift register from i_reg_data on the SCL falling edge that enters RD_DATA.
REQ-028 SHALL increment o_reg_addr 1 clk after the TX shift-register load.
REQ-029 SHALL shift TX data MSB first; a 0 bit drives o_sda_oe=1 and a 1 bit drives o_sda_oe=0.
REQ-030 SHALL in RD_ACK move to RD_DATA on master ACK (SDA=0), and on master NACK (SDA=1) move to IDLE and release SDA.
REQ-031 SHALL hold o_reg_ce, o_reg_we, o_reg_oe and o_reg_data unchanged except during the strobe and read phases defined above.
REQ-032 SHALL retain o_reg_addr across transactions until it is reloaded or incremented.
REQ-033 SHALL discard a partially received byte on START or STOP and issue no write strobe for it.
REQ-034 SHALL never stretch SCL.

Reset
REQ-035 SHALL, while i_iic_rst_n=0, force state=IDLE and o_sda_oe=0, o_reg_ce=0, o_reg_we=0, o_reg_oe=0, o_reg_addr=0, o_reg_data=0, o_busy=0, and clear all shift registers and bit counters.
REQ-036 SHALL, on reset assertion mid-transfer, release SDA asynchronously, and after deassertion ignore the bus until the next START.

Configuration
REQ-037 SHALL, with macro IIC_GLITCH_FILT_EN defined, pass each synchronised line through a 3-sample majority filter, adding 2 clk of latency.
REQ-038 SHALL, with IIC_GLITCH_FILT_EN undefined, use the 2-flop synchronised lines directly, so a 1-clk glitch is treated as a real edge.

Structure
REQ-039 SHALL place the FSM state encoding and the defaults for SLAVE_ADDR, IIC_AW and IIC_DW in shared package iic_pkg.
REQ-040 SHALL implement synchroniser plus optional filter as sub-module iic_line_filter, instantiated once for SCL and once for SDA.

Verification
REQ-041 SHALL cover: S, 0xA0, 0x00, 0xC3, P -> three ACKs and one 1-clk strobe with o_reg_addr=0 and o_reg_data=0xC3; final o_reg_addr=1.
REQ-042 SHALL cover: S, 0xA0, 0x01, Sr, 0xA1, read with NACK, P, with i_reg_data=0x32 -> byte 0x32 returned, o_reg_oe high only during the read, then IDLE.
REQ-043 SHALL cover: S, 0xA2, ... -> NACK on the address byte, no o_reg_ce/o_reg_we activity, o_busy low after the 9th SCL.
REQ-044 SHALL cover: S, 0xA0, 0x03, 0xAA, 0x55, P -> strobes at addr 3 (0xAA) then addr 0 (0x55), showing wrap-around.
REQ-045 SHALL cover: STOP after 4 bits of a data byte -> no strobe, IDLE, SDA released; and reset asserted during RD_DATA -> o_sda_oe=0 immediately.
REQ-046 SHALL cover, with IIC_GLITCH_FILT_EN: a 1-clk low pulse on SCL inside a bit -> no bit counted and the transfer completes correctly.
